// File: rtl/data_memory_bytelane_if.sv
// Load/store bus between the datapath and the byte-lane data memory.
interface data_memory_bytelane_if #(parameter int ADDR_WIDTH = 10);
  logic                  memRead;
  logic                  memWrite;
  logic [1:0]            size;
  logic                  unsignedLoad;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           writeData;
  logic [31:0]           readData;
  logic                  readValid;
  logic                  misaligned;
  logic                  ready;

  modport master (
    output memRead, memWrite, size, unsignedLoad, addr, writeData,
    input  readData, readValid, misaligned, ready
  );
  modport slave (
    input  memRead, memWrite, size, unsignedLoad, addr, writeData,
    output readData, readValid, misaligned, ready
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory: lb/lbu/lh/lhu/lw loads (one-cycle registered), sb/sh/sw
// stores, misalignment flagging and an optional post-reset zero fill.
module data_memory_bytelane_lane #(
  parameter int WA = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [WA-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**WA];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  // Combinational read sampled by the top at the same edge gives read-first.
  assign rdata = mem[idx];
endmodule

module data_memory_bytelane #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_bytelane_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int WA        = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << WA;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]                    st;
  logic [WA-1:0]                 cnt;
  logic                          rdy, legal, do_rd, do_wr, fill_we;
  logic [NUM_LANES-1:0]          lane_sel, lane_we;
  logic [WA-1:0]                 idx;
  logic [NUM_LANES-1:0][7:0]     wword, rword;
  logic [7:0]                    bsel;
  logic [15:0]                   hsel;
  logic [31:0]                   ldata;
  logic [31:0]                   rd_q;
  logic                          vld_q, mis_q;

  assign rdy     = (st == ST_READY);
  assign fill_we = CLEAR_ON_RESET && (st == ST_INIT);
  assign do_rd   = rdy & bus.memRead  & legal;
  assign do_wr   = rdy & bus.memWrite & legal;
  assign idx     = rdy ? bus.addr[ADDR_WIDTH-1:2] : cnt;

  always_comb begin
    legal    = 1'b0;
    lane_sel = '1;
    wword    = bus.writeData;
    case (bus.size)
      2'b00: begin
        legal    = 1'b1;
        lane_sel = 4'b0001 << bus.addr[1:0];
        wword    = {NUM_LANES{bus.writeData[7:0]}};
      end
      2'b01: begin
        legal    = ~bus.addr[0];
        lane_sel = bus.addr[1] ? 4'b1100 : 4'b0011;
        wword    = {2{bus.writeData[15:0]}};
      end
      2'b10:   legal = (bus.addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
    if (fill_we) wword = '0;
  end

  assign lane_we = fill_we ? '1 : (do_wr ? lane_sel : '0);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_memory_bytelane_lane #(.WA(WA)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (idx),
      .wdata (wword[i]),
      .rdata (rword[i])
    );
  end

  // Right-align the selected byte/half, then sign- or zero-extend.
  always_comb begin
    bsel  = rword[bus.addr[1:0]];
    hsel  = bus.addr[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    ldata = rword;
    case (bus.size)
      2'b00:   ldata = {{24{~bus.unsignedLoad & bsel[7]}}, bsel};
      2'b01:   ldata = {{16{~bus.unsignedLoad & hsel[15]}}, hsel};
      default: ldata = rword;
    endcase
  end

  // Fill walks every word once; without fill the first edge goes straight to READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_INIT;
      cnt <= '0;
    end else if (st == ST_INIT) begin
      if (!CLEAR_ON_RESET || cnt == WA'(DEPTH - 1)) st <= ST_READY;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      vld_q <= do_rd;
      mis_q <= rdy & (bus.memRead | bus.memWrite) & ~legal;
      if (do_rd) rd_q <= ldata;
    end
  end

  assign bus.readData   = rd_q;
  assign bus.readValid  = vld_q;
  assign bus.misaligned = mis_q;
  assign bus.ready      = rdy;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Self-checking bench: vector table feeding a scoreboard queue, plus reset/fill sequences.
module tb_data_memory_bytelane;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_bytelane_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_bytelane #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [1:0]    sz;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   exp_d;
    logic          exp_v;
    logic          exp_m;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        v;
    logic        m;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [AW-1:0] a, input logic [31:0] wd,
                              input logic [31:0] ed, input logic ev, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.exp_d = ed; v.exp_v = ev; v.exp_m = em;
    return v;
  endfunction

  task automatic idle();
    bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.size = 2'b10;
    bus.unsignedLoad = 1'b0; bus.addr = '0; bus.writeData = '0;
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    bus.memRead = v.rd; bus.memWrite = v.wr; bus.size = v.sz;
    bus.unsignedLoad = v.uns; bus.addr = v.addr; bus.writeData = v.wd;
    e.id = id; e.d = v.exp_d; e.v = v.exp_v; e.m = v.exp_m;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Requests during the fill must be ignored without pulses.
  task automatic fill_cycles(input int n, input int done_at);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d ready", i), 32'(bus.ready), 32'(i == done_at));
      chk($sformatf("fill%0d readValid", i), 32'(bus.readValid), 32'd0);
      chk($sformatf("fill%0d misaligned", i), 32'(bus.misaligned), 32'd0);
      if (i < n) begin
        bus.memRead = 1'b1; bus.memWrite = i[0];
        bus.size = i[1] ? 2'b11 : 2'b10;
        bus.addr = i[2] ? 6'h11 : 6'h10;
        bus.writeData = 32'hFFFF_FFFF;
      end
    end
    idle();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " readData"},   bus.readData,          32'd0);
    chk({tag, " readValid"},  32'(bus.readValid),    32'd0);
    chk({tag, " misaligned"}, 32'(bus.misaligned),   32'd0);
    chk({tag, " ready"},      32'(bus.ready),        32'd0);
  endtask

  // Scoreboard side: one expectation per driven cycle, compared after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("vec%0d readData", e.id),   bus.readData,        e.d);
        chk($sformatf("vec%0d readValid", e.id),  32'(bus.readValid),  32'(e.v));
        chk($sformatf("vec%0d misaligned", e.id), 32'(bus.misaligned), 32'(e.m));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd wr sz uns addr wd | readData valid mis
    tbl.push_back(mk(0,1,2'b10,0,6'h10,32'h8899AABB, 32'h00000000,0,0));
    tbl.push_back(mk(1,0,2'b00,0,6'h10,32'h0,        32'hFFFFFFBB,1,0));
    tbl.push_back(mk(1,0,2'b00,1,6'h11,32'h0,        32'h000000AA,1,0));
    tbl.push_back(mk(1,0,2'b01,0,6'h12,32'h0,        32'hFFFF8899,1,0));
    tbl.push_back(mk(1,0,2'b01,1,6'h10,32'h0,        32'h0000AABB,1,0));
    tbl.push_back(mk(1,0,2'b10,1,6'h10,32'h0,        32'h8899AABB,1,0));
    tbl.push_back(mk(0,1,2'b00,0,6'h11,32'h000000CC, 32'h8899AABB,0,0));
    tbl.push_back(mk(0,1,2'b01,0,6'h12,32'h00001234, 32'h8899AABB,0,0));
    tbl.push_back(mk(1,0,2'b10,0,6'h10,32'h0,        32'h1234CCBB,1,0));
    tbl.push_back(mk(1,0,2'b01,0,6'h13,32'h0,        32'h1234CCBB,0,1));
    tbl.push_back(mk(0,1,2'b10,0,6'h12,32'hFFFFFFFF, 32'h1234CCBB,0,1));
    tbl.push_back(mk(1,0,2'b10,0,6'h11,32'h0,        32'h1234CCBB,0,1));
    tbl.push_back(mk(1,0,2'b11,0,6'h10,32'h0,        32'h1234CCBB,0,1));
    tbl.push_back(mk(0,1,2'b11,0,6'h10,32'hFFFFFFFF, 32'h1234CCBB,0,1));
    tbl.push_back(mk(1,0,2'b10,0,6'h10,32'h0,        32'h1234CCBB,1,0));
    tbl.push_back(mk(0,1,2'b10,0,6'h20,32'h11111111, 32'h1234CCBB,0,0));
    tbl.push_back(mk(1,1,2'b10,0,6'h20,32'hDEADBEEF, 32'h11111111,1,0));
    tbl.push_back(mk(1,0,2'b10,0,6'h20,32'h0,        32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,0,2'b00,0,6'h23,32'h0,        32'hFFFFFFDE,1,0));
    tbl.push_back(mk(1,0,2'b00,1,6'h22,32'h0,        32'h000000AD,1,0));
    tbl.push_back(mk(1,0,2'b01,0,6'h20,32'h0,        32'hFFFFBEEF,1,0));
    tbl.push_back(mk(1,0,2'b01,1,6'h22,32'h0,        32'h0000DEAD,1,0));
    tbl.push_back(mk(0,0,2'b10,0,6'h00,32'h0,        32'h0000DEAD,0,0));
    tbl.push_back(mk(0,1,2'b00,0,6'h23,32'hFFFFFF7F, 32'h0000DEAD,0,0));
    tbl.push_back(mk(1,0,2'b10,0,6'h20,32'h0,        32'h7FADBEEF,1,0));
    tbl.push_back(mk(1,0,2'b00,0,6'h23,32'h0,        32'h0000007F,1,0));
    tbl.push_back(mk(1,1,2'b01,0,6'h21,32'h0,        32'h0000007F,0,1));
    tbl.push_back(mk(1,0,2'b01,0,6'h22,32'h0,        32'h00007FAD,1,0));
    tbl.push_back(mk(1,0,2'b00,1,6'h10,32'h0,        32'h000000BB,1,0));
    tbl.push_back(mk(0,1,2'b01,0,6'h20,32'hABCD8001, 32'h000000BB,0,0));
    tbl.push_back(mk(1,0,2'b10,0,6'h20,32'h0,        32'h7FAD8001,1,0));
    tbl.push_back(mk(1,0,2'b01,0,6'h20,32'h0,        32'hFFFF8001,1,0));

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    fill_cycles(16, 16);

    foreach (tbl[i]) apply(tbl[i], i);
    drain();

    // Async reset from READY with a nonzero readData.
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("reset in READY");

    // Abort the fill at cycle 5; the next fill must take the full 16 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    fill_cycles(5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("reset in INIT");
    @(negedge clk);
    rst_n = 1'b1;
    fill_cycles(16, 16);

    // Every word written by the table above must now read back as zero.
    for (int w = 0; w < 16; w++)
      apply(mk(1,0,2'b10,0,AW'(w*4),32'h0, 32'h00000000,1,0), 100 + w);
    apply(mk(1,0,2'b00,0,6'h3F,32'h0, 32'h00000000,1,0), 116);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
